// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// UART_RX_PARITY_EN adds the PARITY state (8E1 frames).
package uart_pkg;

    localparam int UART_DATA_BITS              = 8;
    localparam int UART_CLOCKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        RX_PARITY    = 3'd3,
`endif
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } uart_rx_state_t;

    // Even parity holds when data plus parity bit carry an even number of ones.
    function automatic logic uart_even_parity_bad(
        input logic [UART_DATA_BITS-1:0] data,
        input logic                      parity_bit
    );
        return ^{data, parity_bit};
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input; flops load RESET_VALUE on reset.
module uart_rx_sync #(
    parameter logic RESET_VALUE = 1'b1,
    parameter int   STAGES      = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] stage_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    stage_reg[gi] <= RESET_VALUE;
                end else if (gi == 0) begin
                    stage_reg[gi] <= i_async;
                end else begin
                    stage_reg[gi] <= stage_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign o_sync = stage_reg[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// with a single-entry valid/ready output register and one-cycle error pulses.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT_DEFAULT
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_uart_rx,
    output logic [UART_DATA_BITS-1:0] o_data,
    output logic                      o_data_valid,
    input  logic                      i_data_ready,
    output logic                      o_frame_error,
    output logic                      o_parity_error,
    output logic                      o_overrun
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_rx_sync #(
        .RESET_VALUE (1'b1),
        .STAGES      (2)
    ) u_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (i_uart_rx),
        .o_sync  (rx_s)
    );

    uart_rx_state_t              state_reg;
    logic [CW-1:0]               count_reg;
    logic [2:0]                  bit_idx_reg;
    logic [UART_DATA_BITS-1:0]   shift_reg;
    logic [UART_DATA_BITS-1:0]   data_reg;
    logic                        valid_reg;
    logic                        frame_err_reg;
    logic                        overrun_reg;
`ifdef UART_RX_PARITY_EN
    logic                        parity_bad_reg;
    logic                        parity_err_reg;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg     <= RX_IDLE;
            count_reg     <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
            // A delivery later in this block overrides this clear.
            if (valid_reg && i_data_ready) begin
                valid_reg <= 1'b0;
            end

            case (state_reg)
                RX_IDLE: begin
                    count_reg <= '0;
                    if (!rx_s) begin
                        state_reg <= RX_START;
                    end
                end

                RX_START: begin
                    if (count_reg == HALF_LAST) begin
                        count_reg <= '0;
                        if (!rx_s) begin
                            state_reg   <= RX_DATA;
                            bit_idx_reg <= '0;
`ifdef UART_RX_PARITY_EN
                            parity_bad_reg <= 1'b0;
`endif
                        end else begin
                            state_reg <= RX_IDLE;
                        end
                    end else begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end

                RX_DATA: begin
                    if (count_reg == BIT_LAST) begin
                        count_reg   <= '0;
                        shift_reg   <= {rx_s, shift_reg[UART_DATA_BITS-1:1]};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_reg <= RX_PARITY;
`else
                            state_reg <= RX_STOP;
`endif
                        end
                    end else begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end

`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (count_reg == BIT_LAST) begin
                        count_reg      <= '0;
                        parity_bad_reg <= uart_even_parity_bad(shift_reg, rx_s);
                        state_reg      <= RX_STOP;
                    end else begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end
`endif

                RX_STOP: begin
                    if (count_reg == BIT_LAST) begin
                        count_reg <= '0;
                        if (!rx_s) begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= RX_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_bad_reg) begin
                            parity_err_reg <= 1'b1;
                            state_reg      <= RX_IDLE;
`endif
                        end else begin
                            state_reg <= RX_IDLE;
                            if (!valid_reg || i_data_ready) begin
                                data_reg  <= shift_reg;
                                valid_reg <= 1'b1;
                            end else begin
                                overrun_reg <= 1'b1;
                            end
                        end
                    end else begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end

                // A held-low line (break) must return high before a new start is accepted.
                RX_WAIT_HIGH: begin
                    count_reg <= '0;
                    if (rx_s) begin
                        state_reg <= RX_IDLE;
                    end
                end

                default: begin
                    count_reg <= '0;
                    state_reg <= RX_IDLE;
                end
            endcase
        end
    end

    assign o_data        = data_reg;
    assign o_data_valid  = valid_reg;
    assign o_frame_error = frame_err_reg;
    assign o_overrun     = overrun_reg;
`ifdef UART_RX_PARITY_EN
    assign o_parity_error = parity_err_reg;
`else
    assign o_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames plus randomized frames
// checked against a frame-level outcome model.
module tb_uart_rx_core;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 3 + HALF + 10 * CPB;
`else
    localparam int LAT = 3 + HALF + 9 * CPB;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       fe;
    logic       pe;
    logic       ov;

    uart_rx_core #(.CLOCKS_PER_BIT(CPB)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_uart_rx      (rx),
        .o_data         (data),
        .o_data_valid   (valid),
        .i_data_ready   (ready),
        .o_frame_error  (fe),
        .o_parity_error (pe),
        .o_overrun      (ov)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: counts flag cycles, records handshaked bytes and rise time of valid.
    int         cyc = 0;
    int         rise_cyc = 0;
    int         n_fe = 0;
    int         n_pe = 0;
    int         n_ov = 0;
    logic [7:0] rx_q[$];
    logic       valid_q = 1'b0;
    logic       ready_q = 1'b0;
    logic [7:0] hold_q = 8'h00;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (fe) n_fe++;
            if (pe) n_pe++;
            if (ov) n_ov++;
            if (valid && !valid_q) rise_cyc = cyc;
            if (valid && valid_q && !ready_q) check_value("held_stable", {24'h0, data}, {24'h0, hold_q});
            if (valid && ready) rx_q.push_back(data);
            valid_q = valid;
            ready_q = ready;
            hold_q  = data;
        end else begin
            valid_q = 1'b0;
            ready_q = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    // Frame-level stimulus: start, 8 data bits LSB first, optional parity, stop.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_bit);
`endif
        drive_bit(stop_bit);
    endtask

    function automatic logic good_parity(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2 == 1);
    endfunction

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        check_value({tag, "_count"}, rx_q.size(), 1);
        if (rx_q.size() > 0) check_value(tag, {24'h0, rx_q[0]}, {24'h0, exp});
        rx_q.delete();
    endtask

    task automatic expect_none(input string tag);
        check_value({tag, "_bytes"}, rx_q.size(), 0);
        rx_q.delete();
    endtask

    int fe0, pe0, ov0, start_cyc;

    task automatic snap();
        fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
    endtask

    task automatic expect_flags(input string tag, input int efe, input int epe, input int eov);
        check_value({tag, "_fe"}, n_fe - fe0, efe);
        check_value({tag, "_pe"}, n_pe - pe0, epe);
        check_value({tag, "_ov"}, n_ov - ov0, eov);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic bad_stop, bad_par;
        int gap;

        // Reset state
        tick(4);
        check_value("rst_data", {24'h0, data}, 32'h0);
        check_value("rst_valid", {31'h0, valid}, 32'h0);
        check_value("rst_flags", {29'h0, fe, pe, ov}, 32'h0);
        rst = 1'b0;
        tick(4);

        // Single frame, exact latency
        snap();
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1, good_parity(8'hA5));
        tick(2 * CPB);
        check_value("latency", rise_cyc - start_cyc, LAT);
        expect_byte("a5", 8'hA5);
        expect_flags("a5", 0, 0, 0);

        // Half-bit glitch is ignored, then a normal frame still arrives
        snap();
        rx = 1'b0;
        tick(HALF);
        rx = 1'b1;
        tick(3 * CPB);
        expect_none("glitch");
        expect_flags("glitch", 0, 0, 0);
        send_frame(8'h5A, 1'b1, good_parity(8'h5A));
        tick(CPB);
        expect_byte("after_glitch", 8'h5A);

        // Stop bit low with extended break
        snap();
        send_frame(8'h3C, 1'b0, good_parity(8'h3C));
        tick(40);
        rx = 1'b1;
        tick(2 * CPB);
        expect_none("framing");
        expect_flags("framing", 1, 0, 0);
        send_frame(8'h81, 1'b1, good_parity(8'h81));
        tick(CPB);
        expect_byte("after_break", 8'h81);

        // Overrun: two back-to-back bytes with no consumer
        snap();
        ready = 1'b0;
        send_frame(8'h11, 1'b1, good_parity(8'h11));
        send_frame(8'h22, 1'b1, good_parity(8'h22));
        tick(CPB);
        check_value("ovr_data", {24'h0, data}, 32'h11);
        check_value("ovr_valid", {31'h0, valid}, 32'h1);
        expect_flags("ovr", 0, 0, 1);
        ready = 1'b1;
        tick(2);
        check_value("ovr_drained", {31'h0, valid}, 32'h0);
        expect_byte("ovr_first", 8'h11);

        // Handshake in exactly the delivery cycle of the second byte
        snap();
        ready = 1'b0;
        send_frame(8'h11, 1'b1, good_parity(8'h11));
        tick(CPB);
        fork
            send_frame(8'h22, 1'b1, good_parity(8'h22));
            begin
                tick(LAT - 1);
                ready = 1'b1;
                tick(1);
                ready = 1'b0;
            end
        join
        tick(CPB);
        expect_byte("coincide_first", 8'h11);
        check_value("coincide_data", {24'h0, data}, 32'h22);
        check_value("coincide_valid", {31'h0, valid}, 32'h1);
        expect_flags("coincide", 0, 0, 0);
        ready = 1'b1;
        tick(2);
        expect_byte("coincide_second", 8'h22);

        // Reset mid-frame drops held byte and aborts the frame silently
        ready = 1'b0;
        send_frame(8'h44, 1'b1, good_parity(8'h44));
        rx = 1'b0;
        tick(3 * CPB);
        rst = 1'b1;
        tick(3);
        check_value("midrst_valid", {31'h0, valid}, 32'h0);
        check_value("midrst_data", {24'h0, data}, 32'h0);
        rx = 1'b1;
        rst = 1'b0;
        snap();
        rx_q.delete();
        ready = 1'b1;
        tick(12 * CPB);
        expect_none("midrst");
        expect_flags("midrst", 0, 0, 0);

`ifdef UART_RX_PARITY_EN
        // Parity checks on 0x07
        snap();
        send_frame(8'h07, 1'b1, 1'b0);
        tick(CPB);
        expect_none("par_bad");
        expect_flags("par_bad", 0, 1, 0);
        send_frame(8'h07, 1'b1, 1'b1);
        tick(CPB);
        expect_byte("par_good", 8'h07);
`endif

        // Randomized frames against the frame-outcome model
        for (int k = 0; k < 24; k++) begin
            d = 8'($urandom);
            bad_stop = ($urandom_range(0, 5) == 0);
            bad_par = 1'b0;
`ifdef UART_RX_PARITY_EN
            bad_par = ($urandom_range(0, 4) == 0);
`endif
            snap();
            send_frame(d, !bad_stop, good_parity(d) ^ bad_par);
            rx = 1'b1;
            gap = bad_stop ? int'($urandom_range(4, 40)) : int'($urandom_range(0, 20));
            if (bad_stop) begin
                expect_none("rand_fe");
                expect_flags("rand_fe", 1, 0, 0);
            end else if (bad_par) begin
                expect_none("rand_pe");
                expect_flags("rand_pe", 0, 1, 0);
            end else begin
                expect_byte("rand_byte", d);
                expect_flags("rand_ok", 0, 0, 0);
            end
            $display("[TB] frame %0d data=0x%02h bad_stop=%0d bad_par=%0d gap=%0d", k, d, bad_stop, bad_par, gap);
            tick(gap);
        end

        tick(2 * CPB);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
